// File: rtl/uart_link_pkg.sv
// Shared constants, tx FSM encoding and counter helper for the uart host-link controller.
package uart_link_pkg;
    localparam int COUNT_W = 16;
    localparam int BYTE_W  = 8;

    typedef logic [1:0] tx_state_t;
    localparam tx_state_t TX_IDLE      = 2'd0;
    localparam tx_state_t TX_START     = 2'd1;
    localparam tx_state_t TX_WAIT_ACK  = 2'd2;
    localparam tx_state_t TX_WAIT_DONE = 2'd3;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == {COUNT_W{1'b1}}) ? v : v + COUNT_W'(1);
    endfunction
endpackage

// File: rtl/uart_link_ctrl_header_assembler.sv
// Collects received bytes into a header frame; an idle gap or a framing error
// throws away a partially assembled header.
module header_assembler
    import uart_link_pkg::*;
#(
    parameter int HEADER_BYTES = 80,
    parameter int GAP_TIMEOUT  = 50000
) (
    input  logic                             fpga_clock,
    input  logic                             reset,
    input  logic                             rx_valid,
    input  logic [BYTE_W-1:0]                rx_byte,
    input  logic                             rx_error,
    output logic [HEADER_BYTES*BYTE_W-1:0]   header_out,
    output logic                             header_valid
);
    localparam int HDR_W = HEADER_BYTES * BYTE_W;
    localparam int IDX_W = $clog2(HEADER_BYTES + 1);
    localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(HEADER_BYTES - 1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(GAP_TIMEOUT);

    logic [HDR_W-1:0] staging_q, staging_d, shifted;
    logic [HDR_W-1:0] header_q, header_d;
    logic [IDX_W-1:0] idx_q, idx_d, start_idx;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             header_valid_q, header_valid_d;
    logic             timed_out;

    always_comb begin
        // A byte arriving in the timeout cycle already belongs to a fresh header.
        timed_out      = (idx_q != '0) && (gap_q == GAP_LIMIT);
        start_idx      = timed_out ? '0 : idx_q;
        shifted        = (staging_q << BYTE_W) | HDR_W'(rx_byte);
        staging_d      = staging_q;
        header_d       = header_q;
        header_valid_d = 1'b0;
        idx_d          = start_idx;
        gap_d          = gap_q;
        if (rx_valid) begin
            gap_d = '0;
            if (rx_error) begin
                idx_d = '0;
            end else begin
                staging_d = shifted;
                if (start_idx == LAST_IDX) begin
                    header_d       = shifted;
                    header_valid_d = 1'b1;
                    idx_d          = '0;
                end else begin
                    idx_d = start_idx + IDX_W'(1);
                end
            end
        end else if (timed_out || (idx_q == '0)) begin
            gap_d = '0;
        end else begin
            gap_d = gap_q + GAP_W'(1);
        end
    end

    always_ff @(posedge fpga_clock) begin
        if (reset) begin
            idx_q          <= '0;
            gap_q          <= '0;
            header_q       <= '0;
            header_valid_q <= 1'b0;
        end else begin
            idx_q          <= idx_d;
            gap_q          <= gap_d;
            header_q       <= header_d;
            header_valid_q <= header_valid_d;
        end
    end

    always_ff @(posedge fpga_clock) begin
        staging_q <= staging_d;
    end

    assign header_out   = header_q;
    assign header_valid = header_valid_q;
endmodule

// File: rtl/uart_link_ctrl.sv
// Host-link controller: header reception via header_assembler, byte counters,
// and a handshake FSM that serialises a nonce MS byte first into the uart.
module uart_link_ctrl
    import uart_link_pkg::*;
#(
    parameter int HEADER_BYTES = 80,
    parameter int NONCE_BYTES  = 4,
    parameter int GAP_TIMEOUT  = 50000,
    parameter int HALF_DUPLEX  = 1
) (
    input  logic                            fpga_clock,
    input  logic                            reset,
    input  logic                            rx_valid,
    input  logic [BYTE_W-1:0]               rx_byte,
    input  logic                            rx_error,
    input  logic                            rx_active,
    output logic                            tx_start,
    output logic [BYTE_W-1:0]               tx_byte,
    input  logic                            tx_busy,
    output logic [HEADER_BYTES*BYTE_W-1:0]  header_out,
    output logic                            header_valid,
    input  logic [NONCE_BYTES*BYTE_W-1:0]   nonce_in,
    input  logic                            nonce_valid,
    output logic                            nonce_ready,
    output logic                            tx_done,
    output logic [COUNT_W-1:0]              rx_count,
    output logic [COUNT_W-1:0]              err_count
);
    localparam int NONCE_W = NONCE_BYTES * BYTE_W;
    localparam int REM_W   = $clog2(NONCE_BYTES + 1);

    header_assembler #(
        .HEADER_BYTES (HEADER_BYTES),
        .GAP_TIMEOUT  (GAP_TIMEOUT)
    ) u_header_assembler (
        .fpga_clock   (fpga_clock),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .rx_error     (rx_error),
        .header_out   (header_out),
        .header_valid (header_valid)
    );

    logic [COUNT_W-1:0] rx_count_q, rx_count_d, err_count_q, err_count_d;
    tx_state_t          state_q, state_d;
    logic [NONCE_W-1:0] shift_q, shift_d;
    logic [REM_W-1:0]   remaining_q, remaining_d;
    logic [BYTE_W-1:0]  tx_byte_q, tx_byte_d;
    logic               tx_start_q, tx_start_d, tx_done_q, tx_done_d;
    logic               rx_hold;

    always_comb begin
        rx_count_d  = rx_count_q;
        err_count_d = err_count_q;
        if (rx_valid && !rx_error) rx_count_d  = sat_inc(rx_count_q);
        if (rx_valid &&  rx_error) err_count_d = sat_inc(err_count_q);
    end

    // In half-duplex links the host cannot listen while it is still sending to us.
    assign rx_hold = (HALF_DUPLEX != 0) && rx_active;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        remaining_d = remaining_q;
        tx_byte_d   = tx_byte_q;
        tx_start_d  = 1'b0;
        tx_done_d   = 1'b0;
        case (state_q)
            TX_IDLE: if (nonce_valid) begin
                shift_d     = nonce_in;
                remaining_d = REM_W'(NONCE_BYTES);
                state_d     = TX_START;
            end
            TX_START: if (!tx_busy && !rx_hold) begin
                tx_start_d = 1'b1;
                tx_byte_d  = shift_q[NONCE_W-1 -: BYTE_W];
                state_d    = TX_WAIT_ACK;
            end
            TX_WAIT_ACK: if (tx_busy) begin
                shift_d     = shift_q << BYTE_W;
                remaining_d = remaining_q - REM_W'(1);
                state_d     = TX_WAIT_DONE;
            end
            TX_WAIT_DONE: if (!tx_busy) begin
                if (remaining_q != '0) begin
                    state_d = TX_START;
                end else begin
                    tx_done_d = 1'b1;
                    state_d   = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge fpga_clock) begin
        if (reset) begin
            rx_count_q  <= '0;
            err_count_q <= '0;
            state_q     <= TX_IDLE;
            remaining_q <= '0;
            tx_byte_q   <= '0;
            tx_start_q  <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            rx_count_q  <= rx_count_d;
            err_count_q <= err_count_d;
            state_q     <= state_d;
            remaining_q <= remaining_d;
            tx_byte_q   <= tx_byte_d;
            tx_start_q  <= tx_start_d;
            tx_done_q   <= tx_done_d;
        end
    end

    always_ff @(posedge fpga_clock) begin
        shift_q <= shift_d;
    end

    assign nonce_ready = (state_q == TX_IDLE);
    assign tx_start    = tx_start_q;
    assign tx_byte     = tx_byte_q;
    assign tx_done     = tx_done_q;
    assign rx_count    = rx_count_q;
    assign err_count   = err_count_q;
endmodule

// File: tb/tb_uart_link_ctrl.sv
// Self-checking bench for uart_link_ctrl with a scoreboard for headers and tx bytes.
module tb_uart_link_ctrl;
    localparam int HB = 4;
    localparam int NB = 4;
    localparam int GT = 10;
    localparam int HD = 1;

    logic             fpga_clock;
    logic             reset;
    logic             rx_valid;
    logic [7:0]       rx_byte;
    logic             rx_error;
    logic             rx_active;
    logic             tx_start;
    logic [7:0]       tx_byte;
    logic             tx_busy;
    logic [HB*8-1:0]  header_out;
    logic             header_valid;
    logic [NB*8-1:0]  nonce_in;
    logic             nonce_valid;
    logic             nonce_ready;
    logic             tx_done;
    logic [15:0]      rx_count;
    logic [15:0]      err_count;

    uart_link_ctrl #(
        .HEADER_BYTES (HB),
        .NONCE_BYTES  (NB),
        .GAP_TIMEOUT  (GT),
        .HALF_DUPLEX  (HD)
    ) dut (
        .fpga_clock   (fpga_clock),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .rx_error     (rx_error),
        .rx_active    (rx_active),
        .tx_start     (tx_start),
        .tx_byte      (tx_byte),
        .tx_busy      (tx_busy),
        .header_out   (header_out),
        .header_valid (header_valid),
        .nonce_in     (nonce_in),
        .nonce_valid  (nonce_valid),
        .nonce_ready  (nonce_ready),
        .tx_done      (tx_done),
        .rx_count     (rx_count),
        .err_count    (err_count)
    );

    initial fpga_clock = 1'b0;
    always #5 fpga_clock = ~fpga_clock;

    // uart transmitter model: busy for 5 cycles starting the cycle after tx_start
    logic [3:0] busy_cnt;
    always @(posedge fpga_clock) begin
        if (reset)              busy_cnt <= 4'd0;
        else if (tx_start)      busy_cnt <= 4'd5;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 4'd1;
    end
    assign tx_busy = (busy_cnt != 4'd0);

    logic [31:0] hdr_exp_q[$];
    logic [7:0]  txb_exp_q[$];
    int checks = 0;
    int errors = 0;
    int hv_pulses = 0;
    int tx_starts = 0;
    int tx_dones = 0;

    // Advance one cycle and run the scoreboard on whatever the DUT produced.
    task automatic step();
        logic [31:0] eh;
        logic [7:0]  eb;
        @(posedge fpga_clock);
        #1;
        if (header_valid) begin
            hv_pulses++;
            checks++;
            if (hdr_exp_q.size() == 0) begin
                errors++;
                $display("FAIL header_unexpected got %h want none", header_out);
            end else begin
                eh = hdr_exp_q.pop_front();
                if (header_out !== eh) begin
                    errors++;
                    $display("FAIL header_out got %h want %h", header_out, eh);
                end
            end
        end
        if (tx_start) begin
            tx_starts++;
            checks++;
            if (txb_exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_byte_unexpected got %h want none", tx_byte);
            end else begin
                eb = txb_exp_q.pop_front();
                if (tx_byte !== eb) begin
                    errors++;
                    $display("FAIL tx_byte got %h want %h", tx_byte, eb);
                end
            end
        end
        if (tx_done) tx_dones++;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic err);
        rx_valid = 1'b1;
        rx_byte  = b;
        rx_error = err;
        step();
        rx_valid = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check_hdr(input logic [31:0] want);
        checks++;
        if (header_out !== want) begin
            errors++;
            $display("FAIL header_hold got %h want %h", header_out, want);
        end
    endtask

    task automatic push_nonce_bytes(input logic [31:0] n);
        for (int i = 3; i >= 0; i--) txb_exp_q.push_back(n[i*8 +: 8]);
    endtask

    task automatic accept_nonce(input logic [31:0] n);
        int w;
        w = 0;
        while (!nonce_ready && w < 50) begin
            step();
            w++;
        end
        checks++;
        if (!nonce_ready) begin
            errors++;
            $display("FAIL nonce_ready_wait got 0 want 1");
        end
        nonce_in    = n;
        nonce_valid = 1'b1;
        step();
        nonce_valid = 1'b0;
        checks++;
        if (nonce_ready !== 1'b0) begin
            errors++;
            $display("FAIL nonce_ready_after_accept got %b want 0", nonce_ready);
        end
    endtask

    task automatic run_until_done(input int d0, output logic ready_bad);
        ready_bad = 1'b0;
        for (int i = 0; i < 300 && tx_dones == d0; i++) begin
            step();
            if (tx_dones == d0 && nonce_ready) ready_bad = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        check_int("rst_tx_start", int'(tx_start), 0);
        check_int("rst_tx_byte", int'(tx_byte), 0);
        check_int("rst_header_valid", int'(header_valid), 0);
        check_int("rst_tx_done", int'(tx_done), 0);
        check_int("rst_rx_count", int'(rx_count), 0);
        check_int("rst_err_count", int'(err_count), 0);
        check_hdr(32'h0);
        reset = 1'b0;
        step();
        check_int("rst_nonce_ready", int'(nonce_ready), 1);
    endtask

    task automatic test_header_basic();
        int hv0;
        hv0 = hv_pulses;
        hdr_exp_q.push_back(32'h11223344);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        check_int("hdr_latency_pulse", hv_pulses, hv0 + 1);
        idle(3);
        check_hdr(32'h11223344);
        check_int("hdr_one_pulse", hv_pulses, hv0 + 1);
        check_int("hdr_rx_count", int'(rx_count), 4);
    endtask

    task automatic test_back_to_back();
        int hv0;
        hv0 = hv_pulses;
        hdr_exp_q.push_back(32'h55667788);
        hdr_exp_q.push_back(32'h99AABBCC);
        for (int i = 0; i < 8; i++) send_byte(8'h55 + 8'(i * 8'h11), 1'b0);
        idle(2);
        check_int("b2b_pulses", hv_pulses, hv0 + 2);
        check_int("b2b_queue_empty", hdr_exp_q.size(), 0);
        check_int("b2b_rx_count", int'(rx_count), 12);
    endtask

    task automatic test_error_abort();
        int hv0;
        hv0 = hv_pulses;
        hdr_exp_q.push_back(32'hAABBCCDD);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'hFF, 1'b1);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b0);
        idle(2);
        check_hdr(32'hAABBCCDD);
        check_int("err_count_1", int'(err_count), 1);
        check_int("err_one_pulse", hv_pulses, hv0 + 1);
        check_int("err_rx_count", int'(rx_count), 18);
        // framing error on the final byte of a frame
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b1);
        idle(2);
        check_int("err_last_no_pulse", hv_pulses, hv0 + 1);
        check_hdr(32'hAABBCCDD);
        check_int("err_count_2", int'(err_count), 2);
    endtask

    task automatic test_gap_timeout();
        int hv0;
        hv0 = hv_pulses;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        idle(12);
        hdr_exp_q.push_back(32'hA1A2A3A4);
        for (int i = 0; i < 4; i++) send_byte(8'hA1 + 8'(i), 1'b0);
        idle(2);
        check_hdr(32'hA1A2A3A4);
        check_int("gap_pulse", hv_pulses, hv0 + 1);
        // one cycle short of the timeout: partial header survives
        hdr_exp_q.push_back(32'h11223344);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        idle(GT - 1);
        send_byte(8'h44, 1'b0);
        idle(2);
        check_hdr(32'h11223344);
        check_int("gap_keep_pulse", hv_pulses, hv0 + 2);
        // byte arriving exactly at the timeout starts a new header
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        idle(GT);
        hdr_exp_q.push_back(32'hB1B2B3B4);
        for (int i = 0; i < 4; i++) send_byte(8'hB1 + 8'(i), 1'b0);
        idle(2);
        check_hdr(32'hB1B2B3B4);
        check_int("gap_edge_pulse", hv_pulses, hv0 + 3);
        check_int("gap_queue_empty", hdr_exp_q.size(), 0);
    endtask

    task automatic test_nonce_tx();
        int d0, s0;
        logic bad;
        d0 = tx_dones;
        s0 = tx_starts;
        push_nonce_bytes(32'h12345678);
        accept_nonce(32'h12345678);
        run_until_done(d0, bad);
        check_int("tx_done_once", tx_dones, d0 + 1);
        check_int("tx_ready_low", int'(bad), 0);
        check_int("tx_starts_4", tx_starts, s0 + 4);
        check_int("tx_queue_empty", txb_exp_q.size(), 0);
        step();
        check_int("tx_done_pulse_width", int'(tx_done), 0);
        check_int("tx_ready_after", int'(nonce_ready), 1);
    endtask

    task automatic test_half_duplex();
        int d0, s0;
        logic bad;
        d0 = tx_dones;
        s0 = tx_starts;
        rx_active = 1'b1;
        push_nonce_bytes(32'hCAFEF00D);
        accept_nonce(32'hCAFEF00D);
        idle(19);
        check_int("hd_no_start_while_active", tx_starts, s0);
        rx_active = 1'b0;
        run_until_done(d0, bad);
        check_int("hd_done", tx_dones, d0 + 1);
        check_int("hd_starts_4", tx_starts, s0 + 4);
        check_int("hd_ready_low", int'(bad), 0);
    endtask

    task automatic test_reset_mid_tx();
        int d0, s0, w;
        logic bad;
        d0 = tx_dones;
        s0 = tx_starts;
        txb_exp_q.push_back(8'h01);
        txb_exp_q.push_back(8'h02);
        accept_nonce(32'h01020304);
        w = 0;
        while (tx_starts < s0 + 2 && w < 100) begin
            step();
            w++;
        end
        check_int("rmt_second_start", tx_starts, s0 + 2);
        idle(3);
        reset = 1'b1;
        step();
        check_int("rmt_tx_start_low", int'(tx_start), 0);
        check_int("rmt_nonce_ready", int'(nonce_ready), 1);
        reset = 1'b0;
        idle(20);
        check_int("rmt_no_done", tx_dones, d0);
        check_int("rmt_no_more_starts", tx_starts, s0 + 2);
        check_int("rmt_queue_empty", txb_exp_q.size(), 0);
        d0 = tx_dones;
        s0 = tx_starts;
        push_nonce_bytes(32'hDEADBEEF);
        accept_nonce(32'hDEADBEEF);
        run_until_done(d0, bad);
        check_int("rmt_new_done", tx_dones, d0 + 1);
        check_int("rmt_new_starts", tx_starts, s0 + 4);
        check_int("rmt_new_queue_empty", txb_exp_q.size(), 0);
    endtask

    initial begin
        reset       = 1'b1;
        rx_valid    = 1'b0;
        rx_byte     = 8'h00;
        rx_error    = 1'b0;
        rx_active   = 1'b0;
        nonce_in    = '0;
        nonce_valid = 1'b0;
        test_reset();
        test_header_basic();
        test_back_to_back();
        test_error_abort();
        test_gap_timeout();
        test_nonce_tx();
        test_half_duplex();
        test_reset_mid_tx();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
